regfile_mp: RTL and testbench

Parametrised multi-port register file for the processor simulator datapath. It provides NREAD registered read ports and two write ports, an optional hardwired-zero entry, and a sequenced whole-file clear engine. It sits between decode (read addresses) and writeback (two retire lanes). Read data is registered, so it aligns with the execute-stage pipeline register.

---
 rtl/regfile_mp.sv | 149 ++++++++++++++
 tb/tb_regfile_mp.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD registered read ports, two write ports, optional zero entry,
// and a sequenced clear sweep. Define REGFILE_BYPASS_EN for write-first forwarding on reads.

module regfile_mp_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter bit BYPASS   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sweep,
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] entry,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] rd
);
  logic [DATA_W-1:0] nxt;

  always_comb begin
    nxt = entry;
    if (BYPASS) begin
      if (we0 && wa0 == ra) nxt = wd0;
      if (we1 && wa1 == ra) nxt = wd1;
    end
    // Zero entry and sweep override any forwarded data.
    if (sweep || (ZERO_REG != 0 && ra == '0)) nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd <= '0;
    else     rd <= nxt;
  end
endmodule

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  output logic                    busy,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       wa0,
  input  logic [DATA_W-1:0]       wd0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       wa1,
  input  logic [DATA_W-1:0]       wd1,
  input  logic [NREAD*ADDR_W-1:0] ra,
  output logic [NREAD*DATA_W-1:0] rd
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr0, wr1, sweep;

  assign sweep = (state == SWEEP);
  assign busy  = sweep;

  // Writes are accepted only in IDLE; address 0 is dropped when it is hardwired.
  assign wr0 = we0 && !sweep && !(ZERO_REG != 0 && wa0 == '0);
  assign wr1 = we1 && !sweep && !(ZERO_REG != 0 && wa1 == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = SWEEP;
          ptr_nxt   = '0;
        end
      end
      SWEEP: begin
        ptr_nxt = ptr + 1'b1;
        // Termination by compare, not wrap, so ptr never relies on overflow.
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (sweep) begin
      mem[ptr] <= '0;
    end else begin
      if (wr0) mem[wa0] <= wd0;
      if (wr1) mem[wa1] <= wd1;  // later assignment gives port 1 priority
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    assign ra_k = ra[k*ADDR_W +: ADDR_W];

    regfile_mp_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rdport (
      .clk  (clk),
      .rst  (rst),
      .sweep(sweep),
      .ra   (ra_k),
      .entry(mem[ra_k]),
      .we0  (wr0),
      .wa0  (wa0),
      .wd0  (wd0),
      .we1  (wr1),
      .wa1  (wa1),
      .wd1  (wd1),
      .rd   (rd[k*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (defaults: 32 entries, 2 read ports, zero entry on).
`timescale 1ns/1ps
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, clr, busy, we0, we1;
  logic [AW-1:0] wa0, wa1;
  logic [DW-1:0] wd0, wd1;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic [DW-1:0] rd0, rd1;

  int n_cmp = 0;
  int n_bad = 0;

  assign rd0 = rd[DW-1:0];
  assign rd1 = rd[2*DW-1:DW];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .busy(busy),
    .we0 (we0),
    .wa0 (wa0),
    .wd0 (wd0),
    .we1 (we1),
    .wa1 (wa1),
    .wd1 (wd1),
    .ra  (ra),
    .rd  (rd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  initial begin
    int cnt;
    bit zero_ok;
    rst = 1'b1; clr = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    ra = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd0", rd0, 32'd0);
    rst = 1'b0;

    // Reads after reset
    set_ra(0, 1); tick;
    chk("rd_a0", rd0, 32'd0);
    chk("rd_a1", rd1, 32'd0);
    set_ra(31, 31); tick;
    chk("rd_a31_p0", rd0, 32'd0);
    chk("rd_a31_p1", rd1, 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);

    // Basic write then read
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; set_ra(0, 0); tick;
    we0 = 1'b0; set_ra(0, 5); tick;
    chk("wr5_rd", rd1, 32'hDEADBEEF);

    // Address 0 is hardwired
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234; set_ra(0, 5); tick;
    chk("zero_same_edge", rd0, 32'd0);
    we0 = 1'b0; tick;
    chk("zero_after", rd0, 32'd0);
    chk("wr5_hold", rd1, 32'hDEADBEEF);

    // Same-edge write/read on entry 7
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h11; tick;
    we1 = 1'b0;
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hA5A5A5A5; set_ra(7, 0); tick;
    we0 = 1'b0;
    chk("same_edge7", rd0, BYP ? 32'hA5A5A5A5 : 32'h11);
    tick;
    chk("next_edge7", rd0, 32'hA5A5A5A5);

    // Both ports to address 9
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h2; set_ra(9, 9); tick;
    we0 = 1'b0; we1 = 1'b0;
    chk("dual9_same", rd0, BYP ? 32'h2 : 32'h0);
    tick;
    chk("dual9_after", rd1, 32'h2);

    // Fill every entry
    for (int i = 0; i < 16; i++) begin
      we0 = 1'b1; wa0 = AW'(2*i);   wd0 = 32'hC000_0000 | 32'(2*i);
      we1 = 1'b1; wa1 = AW'(2*i+1); wd1 = 32'hC000_0000 | 32'(2*i+1);
      tick;
    end
    we0 = 1'b0; we1 = 1'b0;
    set_ra(30, 31); tick;
    chk("fill30", rd0, 32'hC000001E);
    chk("fill31", rd1, 32'hC000001F);
    set_ra(0, 1); tick;
    chk("fill0", rd0, 32'd0);
    chk("fill1", rd1, 32'hC0000001);

    // Clear sweep with writes attempted throughout
    clr = 1'b1; tick; clr = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    we0 = 1'b1; wa0 = 5'd3;  wd0 = 32'hFFFFFFFF;
    we1 = 1'b1; wa1 = 5'd30; wd1 = 32'h5A5A5A5A;
    set_ra(3, 30);
    cnt = 1; zero_ok = 1'b1;
    while (busy === 1'b1 && cnt < 64) begin
      tick;
      if (rd !== '0) zero_ok = 1'b0;
      if (busy === 1'b1) cnt++;
    end
    we1 = 1'b0;
    chk("busy_len", 32'(cnt), 32'd32);
    chk("rd_zero_sweep", 32'(zero_ok), 32'd1);
    // First edge after busy falls must accept a write
    wa0 = 5'd4; wd0 = 32'h77; tick;
    we0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_ra(AW'(2*i), AW'(2*i+1)); tick;
      chk($sformatf("swept%0d", 2*i), rd0, (2*i == 4) ? 32'h77 : 32'd0);
      chk($sformatf("swept%0d", 2*i+1), rd1, 32'd0);
    end

    // Reset in the middle of a sweep
    we0 = 1'b1; wa0 = 5'd20; wd0 = 32'hAAAA;
    we1 = 1'b1; wa1 = 5'd21; wd1 = 32'hBBBB; tick;
    we0 = 1'b0; we1 = 1'b0;
    clr = 1'b1; tick; clr = 1'b0;
    repeat (10) tick;
    chk("busy_mid", 32'(busy), 32'd1);
    rst = 1'b1; #1;
    chk("busy_async", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h55; set_ra(21, 20); tick;
    we0 = 1'b0;
    chk("busy_post_rst", 32'(busy), 32'd0);
    chk("rst_cleared21_a", rd0, 32'd0);
    tick;
    chk("post_rst_wr20", rd1, 32'h55);
    chk("rst_cleared21_b", rd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
